// File: rtl/dpll_core.sv
`timescale 1ns/1ps
// dpll_core: digital PLL built from a phase-accumulator NCO, a bang-bang PFD,
// a slew integrator that trims the frequency word, and lockout/lock detection.
module dpll_core #(
    parameter int ACC_W        = 16,
    parameter int FREQ_W       = 10,
    parameter int FREQ_MIN     = 65,
    parameter int FREQ_DEFAULT = 163,
    parameter int FREQ_MAX     = 524,
    parameter int SLEW_LIMIT   = 508,
    parameter int LOCKOUT_CYC  = 2000,
    parameter int LOCK_CNT     = 16,
    parameter int LOCK_TOL     = 4
) (
    input  logic              clk_50,
    input  logic              rst_n,
    input  logic              fb_in,
    input  logic [1:0]        mode,
    input  logic [ACC_W-1:0]  phase_ofs,
    output logic              nco_out,
    output logic              pll_out,
    output logic [FREQ_W-1:0] freq_word,
    output logic              slew_fast,
    output logic              slew_slow,
    output logic              lockout,
    output logic              locked
);
    localparam int LO_W = $clog2(LOCKOUT_CYC + 1);
    localparam int Q_W  = $clog2(LOCK_CNT + 1);
    localparam int P_W  = $clog2(LOCK_TOL + 2);

    localparam logic [FREQ_W-1:0] CNT_MID = FREQ_W'(1 << (FREQ_W - 1));
    localparam logic [FREQ_W-1:0] CNT_HI  = FREQ_W'((1 << (FREQ_W - 1)) + SLEW_LIMIT);
    localparam logic [FREQ_W-1:0] CNT_LO  = FREQ_W'((1 << (FREQ_W - 1)) - SLEW_LIMIT);
    localparam logic [FREQ_W-1:0] F_MIN   = FREQ_W'(FREQ_MIN);
    localparam logic [FREQ_W-1:0] F_DEF   = FREQ_W'(FREQ_DEFAULT);
    localparam logic [FREQ_W-1:0] F_MAX   = FREQ_W'(FREQ_MAX);
    localparam logic [LO_W-1:0]   LO_MAX  = LO_W'(LOCKOUT_CYC);
    localparam logic [Q_W-1:0]    Q_MAX   = Q_W'(LOCK_CNT);
    localparam logic [P_W-1:0]    P_TOL   = P_W'(LOCK_TOL);
    localparam logic [P_W-1:0]    P_MAX   = P_W'(LOCK_TOL + 1);

    logic              r_fb_s1, r_fb_s2, r_fb_d;
    logic [ACC_W-1:0]  r_acc;
    logic              r_nco, r_pll;
    logic              r_up, r_dn;
    logic [FREQ_W-1:0] r_freq, r_slew_cnt;
    logic [LO_W-1:0]   r_lo_cnt;
    logic [Q_W-1:0]    r_qual;
    logic [P_W-1:0]    r_plen, r_plast;

    logic              w_fb_edge, w_fb_tog, w_nco_rise;
    logic              w_fast, w_slow, w_lockout, w_free, w_track;
    logic [ACC_W-1:0]  w_half, w_step, w_diff;
    logic [FREQ_W-1:0] w_freq_inc, w_freq_dec;

    assign w_fb_edge  = r_fb_s2 & ~r_fb_d;
    assign w_fb_tog   = r_fb_s2 ^ r_fb_d;
    assign w_nco_rise = r_acc[ACC_W-1] & ~r_nco;
    assign w_fast     = r_up & ~r_dn;
    assign w_slow     = r_dn & ~r_up;
    assign w_lockout  = (r_lo_cnt == LO_MAX);
    assign w_free     = (mode == 2'b00);
    assign w_track    = (mode == 2'b01) & ~w_lockout;
    assign w_half     = ACC_W'(r_freq >> 1);
    assign w_diff     = r_acc - phase_ofs;
    // Clamp before stepping so the word can never wrap past a limit.
    assign w_freq_inc = (r_freq >= F_MAX) ? F_MAX : r_freq + 1'b1;
    assign w_freq_dec = (r_freq <= F_MIN) ? F_MIN : r_freq - 1'b1;

    always_comb begin
        w_step = ACC_W'(r_freq);
        if (w_fast) w_step = w_step + w_half;
        if (w_slow) w_step = w_step - w_half;
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_fb_s1    <= 1'b0;
            r_fb_s2    <= 1'b0;
            r_fb_d     <= 1'b0;
            r_acc      <= '0;
            r_nco      <= 1'b0;
            r_pll      <= 1'b0;
            r_up       <= 1'b0;
            r_dn       <= 1'b0;
            r_freq     <= F_DEF;
            r_slew_cnt <= CNT_MID;
            r_lo_cnt   <= '0;
            r_qual     <= '0;
            r_plen     <= '0;
            r_plast    <= P_MAX;
        end else begin
            r_fb_s1 <= fb_in;
            r_fb_s2 <= r_fb_s1;
            r_fb_d  <= r_fb_s2;
            r_acc   <= r_acc + w_step;
            r_nco   <= r_acc[ACC_W-1];
            r_pll   <= w_diff[ACC_W-1];

            if (w_fb_tog)             r_lo_cnt <= '0;
            else if (!w_lockout)      r_lo_cnt <= r_lo_cnt + 1'b1;

            if (w_free) begin
                r_up       <= 1'b0;
                r_dn       <= 1'b0;
                r_slew_cnt <= CNT_MID;
                r_freq     <= F_DEF;
            end else begin
                // Both flags set: clear together and ignore new edges this cycle.
                if (r_up && r_dn) begin
                    r_up <= 1'b0;
                    r_dn <= 1'b0;
                end else begin
                    if (w_fb_edge)  r_up <= 1'b1;
                    if (w_nco_rise) r_dn <= 1'b1;
                end
                if (w_track) begin
                    if (r_slew_cnt >= CNT_HI) begin
                        r_freq     <= w_freq_dec;
                        r_slew_cnt <= CNT_MID;
                    end else if (r_slew_cnt <= CNT_LO) begin
                        r_freq     <= w_freq_inc;
                        r_slew_cnt <= CNT_MID;
                    end else if (w_slow) begin
                        r_slew_cnt <= r_slew_cnt + 1'b1;
                    end else if (w_fast) begin
                        r_slew_cnt <= r_slew_cnt - 1'b1;
                    end
                end
            end

            // Length of the most recently completed slew pulse, saturating.
            if (w_fast || w_slow) begin
                if (r_plen != P_MAX) r_plen <= r_plen + 1'b1;
            end else if (r_plen != '0) begin
                r_plast <= r_plen;
                r_plen  <= '0;
            end

            if (w_fb_edge) begin
                if (r_plast <= P_TOL) begin
                    if (r_qual != Q_MAX) r_qual <= r_qual + 1'b1;
                end else begin
                    r_qual <= '0;
                end
            end
        end
    end

    assign nco_out   = r_nco;
    assign pll_out   = r_pll;
    assign freq_word = r_freq;
    assign slew_fast = w_fast;
    assign slew_slow = w_slow;
    assign lockout   = w_lockout;
    assign locked    = (r_qual == Q_MAX) & ~w_lockout & (mode == 2'b01);

endmodule

// File: tb/tb_dpll_core.sv
`timescale 1ns/1ps
// Directed bench for dpll_core: a default-parameter instance for timing checks
// and a narrow-range, fast-integrator instance for clamp and mode-entry checks.
module tb_dpll_core;
    logic        clk_50 = 1'b0;
    logic        rst_n;
    logic        fb_in, fb_in2;
    logic [1:0]  mode, mode2;
    logic [15:0] phase_ofs;
    logic        nco_out, pll_out, slew_fast, slew_slow, lockout, locked;
    logic [9:0]  freq_word;
    logic        nco2, pll2, fast2, slow2, lockout2, locked2;
    logic [9:0]  freq2;

    int n_cmp = 0;
    int n_bad = 0;

    always #10 clk_50 = ~clk_50;

    dpll_core dut (
        .clk_50(clk_50), .rst_n(rst_n), .fb_in(fb_in), .mode(mode),
        .phase_ofs(phase_ofs), .nco_out(nco_out), .pll_out(pll_out),
        .freq_word(freq_word), .slew_fast(slew_fast), .slew_slow(slew_slow),
        .lockout(lockout), .locked(locked)
    );

    dpll_core #(.FREQ_MAX(166), .SLEW_LIMIT(8)) dut2 (
        .clk_50(clk_50), .rst_n(rst_n), .fb_in(fb_in2), .mode(mode2),
        .phase_ofs(phase_ofs), .nco_out(nco2), .pll_out(pll2),
        .freq_word(freq2), .slew_fast(fast2), .slew_slow(slow2),
        .lockout(lockout2), .locked(locked2)
    );

    task automatic apply_reset(input logic [1:0] m, input logic [1:0] m2);
        rst_n  = 1'b0;
        fb_in  = 1'b0;
        fb_in2 = 1'b0;
        mode   = m;
        mode2  = m2;
        repeat (3) @(posedge clk_50);
        @(negedge clk_50);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        phase_ofs = 16'h0000;
        apply_reset(2'b01, 2'b01);
        fb_in = 1'b1;
        repeat (50) @(posedge clk_50);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({nco_out, pll_out, slew_fast, slew_slow, lockout, locked} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {nco_out, pll_out, slew_fast, slew_slow, lockout, locked});
        end
        n_cmp++;
        if (freq_word !== 10'd163) begin
            n_bad++; $display("FAIL reset_freq: got %0d expected 163", freq_word);
        end
        n_cmp++;
        if (freq2 !== 10'd163) begin
            n_bad++; $display("FAIL reset_freq2: got %0d expected 163", freq2);
        end
    endtask

    task automatic test_free_run;
        int rises[3];
        int nr = 0;
        logic prev = 1'b0;
        apply_reset(2'b00, 2'b00);
        for (int e = 1; e <= 2000; e++) begin
            @(posedge clk_50); #1;
            if (nco_out && !prev && nr < 3) begin rises[nr] = e; nr++; end
            prev = nco_out;
            if (e == 500 || e == 1500) begin
                n_cmp++;
                if (freq_word !== 10'd163) begin
                    n_bad++; $display("FAIL free_freq@%0d: got %0d expected 163", e, freq_word);
                end
            end
            if (e == 1999 || e == 2000) begin
                n_cmp++;
                if (lockout !== (e == 2000)) begin
                    n_bad++; $display("FAIL free_lockout@%0d: got %b expected %b", e, lockout, e == 2000);
                end
            end
        end
        n_cmp++;
        if (nr != 3) begin
            n_bad++; $display("FAIL free_rise_count: got %0d expected 3", nr);
        end else begin
            n_cmp++;
            if (rises[0] < 201 || rises[0] > 203) begin
                n_bad++; $display("FAIL free_first_rise: got %0d expected 201..203", rises[0]);
            end
            for (int k = 1; k < 3; k++) begin
                n_cmp++;
                if (rises[k] - rises[k-1] < 401 || rises[k] - rises[k-1] > 403) begin
                    n_bad++; $display("FAIL free_period%0d: got %0d expected 402+-1", k, rises[k] - rises[k-1]);
                end
            end
        end
        // fb resumes after edge 2001; the toggle is seen two edges later.
        @(posedge clk_50); #1; fb_in = 1'b1;
        @(posedge clk_50); #1;
        @(posedge clk_50); #1;
        n_cmp++;
        if (lockout !== 1'b1) begin
            n_bad++; $display("FAIL resume_hold: got %b expected 1", lockout);
        end
        @(posedge clk_50); #1;
        n_cmp++;
        if (lockout !== 1'b0) begin
            n_bad++; $display("FAIL resume_clear: got %b expected 0", lockout);
        end
    endtask

    // No fb: nco edge leaves slew_slow asserted, integrator steps down every
    // 509 cycles until lockout at cycle 2000 freezes the word at 160.
    task automatic test_idle_track;
        apply_reset(2'b01, 2'b00);
        for (int e = 1; e <= 2600; e++) begin
            @(posedge clk_50); #1;
            if (e == 711 || e == 712 || e == 1220 || e == 1221 || e == 1730 || e == 2600) begin
                int exp_f;
                exp_f = (e < 712) ? 163 : (e < 1221) ? 162 : (e < 1730) ? 161 : 160;
                n_cmp++;
                if (freq_word !== 10'(exp_f)) begin
                    n_bad++; $display("FAIL idle_freq@%0d: got %0d expected %0d", e, freq_word, exp_f);
                end
            end
        end
        n_cmp++;
        if ({lockout, slew_slow, locked} !== 3'b110) begin
            n_bad++; $display("FAIL idle_flags: got %b expected 110", {lockout, slew_slow, locked});
        end
    endtask

    task automatic test_pfd_hold;
        apply_reset(2'b10, 2'b00);
        for (int e = 1; e <= 172; e++) begin
            @(posedge clk_50); #1;
            if (e == 100) fb_in = 1'b1;
            if (e == 102 || e == 103 || e == 169 || e == 170) begin
                logic [1:0] exp_s;
                exp_s = (e == 103 || e == 169) ? 2'b10 : 2'b00;
                n_cmp++;
                if ({slew_fast, slew_slow} !== exp_s) begin
                    n_bad++; $display("FAIL pfd_slew@%0d: got %b expected %b", e, {slew_fast, slew_slow}, exp_s);
                end
            end
            if (e == 171) begin
                n_cmp++;
                if ({dut.r_up, dut.r_dn} !== 2'b00) begin
                    n_bad++; $display("FAIL pfd_clear: got %b expected 00", {dut.r_up, dut.r_dn});
                end
            end
        end
        n_cmp++;
        if (freq_word !== 10'd163) begin
            n_bad++; $display("FAIL hold_freq: got %0d expected 163", freq_word);
        end
    endtask

    task automatic test_coincident;
        apply_reset(2'b10, 2'b00);
        for (int e = 1; e <= 215; e++) begin
            @(posedge clk_50); #1;
            if (e == 200) fb_in = 1'b1;
            if (e >= 195) begin
                n_cmp++;
                if ({slew_fast, slew_slow} !== 2'b00) begin
                    n_bad++; $display("FAIL coin_slew@%0d: got %b expected 00", e, {slew_fast, slew_slow});
                end
            end
            if (e == 203 || e == 204) begin
                n_cmp++;
                if ({dut.r_up, dut.r_dn} !== ((e == 203) ? 2'b11 : 2'b00)) begin
                    n_bad++; $display("FAIL coin_flags@%0d: got %b expected %b", e, {dut.r_up, dut.r_dn},
                                      (e == 203) ? 2'b11 : 2'b00);
                end
            end
        end
    endtask

    task automatic test_clamp;
        logic [9:0] prev_f = 10'd163;
        apply_reset(2'b00, 2'b01);
        for (int e = 1; e <= 3000; e++) begin
            @(posedge clk_50); #1;
            fb_in2 = ((e / 50) % 2) == 1;
            n_cmp++;
            if (freq2 < prev_f || freq2 > 10'd166) begin
                n_bad++; $display("FAIL clamp_mono@%0d: got %0d expected %0d..166", e, freq2, prev_f);
            end
            prev_f = freq2;
        end
        n_cmp++;
        if (freq2 !== 10'd166) begin
            n_bad++; $display("FAIL clamp_max: got %0d expected 166", freq2);
        end
        n_cmp++;
        if (locked2 !== 1'b0) begin
            n_bad++; $display("FAIL clamp_locked: got %b expected 0", locked2);
        end
    endtask

    task automatic test_mode00_entry;
        mode2 = 2'b00;
        #1;
        n_cmp++;
        if (freq2 !== 10'd166) begin
            n_bad++; $display("FAIL entry_before: got %0d expected 166", freq2);
        end
        @(posedge clk_50); #1;
        n_cmp++;
        if ({freq2, fast2, slow2} !== {10'd163, 2'b00}) begin
            n_bad++; $display("FAIL entry_after: got %0d/%b expected 163/00", freq2, {fast2, slow2});
        end
    endtask

    task automatic test_lock_and_reset;
        int first = 0;
        logic prev = 1'b0;
        phase_ofs = 16'h4000;
        apply_reset(2'b01, 2'b00);
        for (int e = 1; e <= 7500; e++) begin
            @(posedge clk_50); #1;
            fb_in = nco_out;
            if (e == 1000) begin
                n_cmp++;
                if (locked !== 1'b0) begin
                    n_bad++; $display("FAIL lock_early: got %b expected 0", locked);
                end
            end
        end
        n_cmp++;
        if ({locked, lockout, freq_word} !== {2'b10, 10'd163}) begin
            n_bad++; $display("FAIL lock_state: got %b/%b/%0d expected 1/0/163", locked, lockout, freq_word);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({nco_out, pll_out, slew_fast, slew_slow, lockout, locked, freq_word} !== {6'b0, 10'd163}) begin
            n_bad++; $display("FAIL async_reset: got %b/%0d expected 000000/163",
                              {nco_out, pll_out, slew_fast, slew_slow, lockout, locked}, freq_word);
        end
        fb_in = 1'b0;
        repeat (2) @(posedge clk_50);
        @(negedge clk_50);
        rst_n = 1'b1;
        for (int e = 1; e <= 300; e++) begin
            @(posedge clk_50); #1;
            if (nco_out && !prev && first == 0) first = e;
            prev = nco_out;
            if (e == 101 || e == 102) begin
                n_cmp++;
                if (pll_out !== (e == 101)) begin
                    n_bad++; $display("FAIL pll_ofs@%0d: got %b expected %b", e, pll_out, e == 101);
                end
            end
        end
        n_cmp++;
        if (first < 201 || first > 203) begin
            n_bad++; $display("FAIL relock_first_rise: got %0d expected 201..203", first);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        fb_in     = 1'b0;
        fb_in2    = 1'b0;
        mode      = 2'b00;
        mode2     = 2'b00;
        phase_ofs = 16'h0000;
        test_reset;
        test_free_run;
        test_idle_track;
        test_pfd_hold;
        test_coincident;
        test_clamp;
        test_mode00_entry;
        test_lock_and_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
